// File: rtl/capture_scheduler_if.sv
// ---------------------------------------------------------------------------
// capture_scheduler_if
// Record output port of capture_scheduler.
//
// Handshake: the master presents a record on cap_valid/cap_ch/cap_val/cap_ovr.
// A record moves when cap_valid && cap_ready are both high at a rising clock
// edge. While cap_valid is high and cap_ready is low, the master holds every
// payload field stable. cap_ready may be high or low at any time, including
// when cap_valid is low. cap_valid does not depend on cap_ready in the same
// cycle.
//
// Signals
//   cap_valid  master -> slave  record valid
//   cap_ready  slave  -> master consumer accepts the record
//   cap_ch     master -> slave  channel that produced the record
//   cap_val    master -> slave  timestamp of the record
//   cap_ovr    master -> slave  channel dropped at least one edge while pending
// ---------------------------------------------------------------------------
interface capture_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cap_valid;
  logic           cap_ready;
  logic [CHW-1:0] cap_ch;
  logic [CW-1:0]  cap_val;
  logic           cap_ovr;

  modport master (
    output cap_valid,
    output cap_ch,
    output cap_val,
    output cap_ovr,
    input  cap_ready
  );

  modport slave (
    input  cap_valid,
    input  cap_ch,
    input  cap_val,
    input  cap_ovr,
    output cap_ready
  );
endinterface

// File: rtl/capture_scheduler.sv
// ---------------------------------------------------------------------------
// capture_scheduler
// Multi-channel input-capture controller. A shared prescaled timebase
// timestamps selected edges on NCH asynchronous inputs. Each channel keeps one
// pending record; a round-robin scheduler drains records through a single
// valid/ready output register and sets per-channel interrupt flags.
//
// Optional feature macro: CAPTURE_FILTER_EN
//   defined   : per-channel glitch filter after the synchronizer; the filtered
//               level only follows the input after FILT_LEN consecutive equal
//               samples, and edges are detected on the filtered level.
//   undefined : no filter logic, FILT_LEN has no effect.
//
// Ports
//   clk            system clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   sig_i          asynchronous capture inputs, one per channel
//   en_i           per-channel enable
//   edge_sel_i     per channel 2 bits: 00 off, 01 rise, 10 fall, 11 both
//   ps_div_i       timebase advances every ps_div_i+1 clocks
//   tb_clr_i       synchronous clear of timebase and prescaler
//   timebase_o     current timebase value
//   cap            record output port (capture_scheduler_if.master)
//   int_flag_o     per-channel capture interrupt flag
//   int_clr_i      write-1-to-clear pulses for int_flag_o
//   dbg_rr_ptr_o   round-robin pointer (scheduler state)
//   dbg_pending_o  per-channel pending bits (channel state)
// ---------------------------------------------------------------------------
module capture_scheduler #(
  parameter int NCH      = 4,
  parameter int CW       = 8,
  parameter int PSW      = 4,
  parameter int FILT_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        sig_i,
  input  logic [NCH-1:0]        en_i,
  input  logic [2*NCH-1:0]      edge_sel_i,
  input  logic [PSW-1:0]        ps_div_i,
  input  logic                  tb_clr_i,
  output logic [CW-1:0]         timebase_o,
  capture_scheduler_if.master   cap,
  output logic [NCH-1:0]        int_flag_o,
  input  logic [NCH-1:0]        int_clr_i,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] dbg_rr_ptr_o,
  output logic [NCH-1:0]        dbg_pending_o
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  // -------------------------------------------------------------------------
  // Timebase and prescaler
  // -------------------------------------------------------------------------
  logic [PSW-1:0] ps_cnt_q, ps_cnt_d;
  logic [CW-1:0]  tb_q, tb_d;

  always_comb begin
    ps_cnt_d = ps_cnt_q + PSW'(1);
    tb_d     = tb_q;
    if (tb_clr_i) begin
      // Clear wins over a coincident increment.
      ps_cnt_d = '0;
      tb_d     = '0;
    end else if (ps_cnt_q == ps_div_i) begin
      ps_cnt_d = '0;
      tb_d     = tb_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_q <= '0;
      tb_q     <= '0;
    end else begin
      ps_cnt_q <= ps_cnt_d;
      tb_q     <= tb_d;
    end
  end

  assign timebase_o = tb_q;

  // -------------------------------------------------------------------------
  // Input path: two-flop synchronizer, optional filter, history flop
  // -------------------------------------------------------------------------
  logic [NCH-1:0] sync1_q, sync2_q, hist_q;
  logic [NCH-1:0] lvl;  // level used for edge detection

`ifdef CAPTURE_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

  logic [NCH-1:0] filt_q, filt_d;
  logic [FCW-1:0] fcnt_q [NCH];
  logic [FCW-1:0] fcnt_d [NCH];

  // fcnt counts how many consecutive samples have disagreed with the filtered
  // level; the FILT_LEN-th disagreeing sample flips the filtered level.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NCH; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        fcnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NCH; i++) begin
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end

  assign lvl = filt_q;
`else
  // Filter length has no meaning without the filter; the empty block keeps
  // the parameter referenced in this build.
  if (FILT_LEN < 0) begin : g_no_filter
  end

  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      // History always tracks the level, even for disabled channels, so a
      // re-enabled channel never sees a stale edge.
      hist_q  <= lvl;
    end
  end

  // Qualified edge events: the level differs from history and the direction
  // is selected for an enabled channel.
  logic [NCH-1:0] edge_hit;

  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      edge_hit[i] = en_i[i] &
                    (( lvl[i] & ~hist_q[i] & edge_sel_i[2*i])   |
                     (~lvl[i] &  hist_q[i] & edge_sel_i[2*i+1]));
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick among pending, enabled channels
  // -------------------------------------------------------------------------
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic [CW-1:0]  stamp_q [NCH];
  logic [CW-1:0]  stamp_d [NCH];
  logic [CHW-1:0] rr_q, rr_d;
  logic [NCH-1:0] eligible;
  logic           found;
  logic [CHW-1:0] pick;
  logic [CHW:0]   scan;

  // A channel whose enable dropped is skipped even before its pending bit
  // clears, so its record can never be issued.
  assign eligible = pending_q & en_i;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan = {1'b0, rr_q} + (CHW+1)'(k);
      if (scan >= (CHW+1)'(NCH)) begin
        scan = scan - (CHW+1)'(NCH);
      end
      if (!found && eligible[scan[CHW-1:0]]) begin
        found = 1'b1;
        pick  = scan[CHW-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register and interrupt flags
  // -------------------------------------------------------------------------
  logic           cv_q, cv_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CW-1:0]  val_q, val_d;
  logic           co_q, co_d;
  logic           load;
  logic [NCH-1:0] pop_vec;
  logic [NCH-1:0] int_flag_q, int_flag_d;

  // The register is free when empty or when its record is taken this cycle.
  assign load = !cv_q || cap.cap_ready;

  always_comb begin
    cv_d    = cv_q;
    ch_d    = ch_q;
    val_d   = val_q;
    co_d    = co_q;
    rr_d    = rr_q;
    pop_vec = '0;
    if (load) begin
      cv_d = found;
      if (found) begin
        ch_d          = pick;
        val_d         = stamp_q[pick];
        co_d          = ovr_q[pick];
        pop_vec[pick] = 1'b1;
        rr_d          = (pick == CHW'(NCH - 1)) ? '0 : pick + CHW'(1);
      end
    end
  end

  // A set from a load beats a coincident clear.
  assign int_flag_d = (int_flag_q & ~int_clr_i) | pop_vec;

  // -------------------------------------------------------------------------
  // Per-channel pending record
  // -------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    ovr_d     = ovr_q;
    for (int i = 0; i < NCH; i++) begin
      stamp_d[i] = stamp_q[i];
      if (!en_i[i]) begin
        pending_d[i] = 1'b0;
        ovr_d[i]     = 1'b0;
      end else if (edge_hit[i]) begin
        if (!pending_q[i] || pop_vec[i]) begin
          // Slot free, or being emptied this cycle: start a fresh record.
          pending_d[i] = 1'b1;
          stamp_d[i]   = tb_q;
          ovr_d[i]     = 1'b0;
        end else begin
          // First stamp is kept; remember that an edge was lost.
          ovr_d[i] = 1'b1;
        end
      end else if (pop_vec[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      ovr_q      <= '0;
      rr_q       <= '0;
      cv_q       <= 1'b0;
      ch_q       <= '0;
      val_q      <= '0;
      co_q       <= 1'b0;
      int_flag_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        stamp_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      ovr_q      <= ovr_d;
      rr_q       <= rr_d;
      cv_q       <= cv_d;
      ch_q       <= ch_d;
      val_q      <= val_d;
      co_q       <= co_d;
      int_flag_q <= int_flag_d;
      for (int i = 0; i < NCH; i++) begin
        stamp_q[i] <= stamp_d[i];
      end
    end
  end

  assign cap.cap_valid  = cv_q;
  assign cap.cap_ch     = ch_q;
  assign cap.cap_val    = val_q;
  assign cap.cap_ovr    = co_q;
  assign int_flag_o     = int_flag_q;
  assign dbg_rr_ptr_o   = rr_q;
  assign dbg_pending_o  = pending_q;

endmodule
